// File: rtl/serial_key_lock_pkg.sv
// Shared types and helpers for the serial key lock.
// The SHIFT_DEBOUNCE_EN macro is consumed by serial_key_lock.sv.
package serial_key_lock_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    // Bits needed to hold any value in 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_key_lock_sync_edge_det.sv
// Synchroniser for an asynchronous strobe, an optional level debouncer,
// and a single-cycle rising-edge pulse taken from the final level.
module sync_edge_det
    import serial_key_lock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter bit DEBOUNCE_EN     = 1'b0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_lvl;
    logic                   lvl;
    logic                   lvl_q;

    // Metastability chain; the last stage is the usable synchronous level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_r <= '0;
        else        sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
    end

    assign sync_lvl = sync_r[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_EN && DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] run_cnt;
            logic          filt;

            // Filtered level follows the input only after a full run of
            // DEBOUNCE_CYCLES consecutive samples that disagree with it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    run_cnt <= '0;
                    filt    <= 1'b0;
                end else if (sync_lvl == filt) begin
                    run_cnt <= '0;
                end else if (run_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    run_cnt <= '0;
                    filt    <= sync_lvl;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end

            assign lvl = filt;
        end else begin : g_raw
            assign lvl = sync_lvl;
        end
    endgenerate

    // Previous level, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= lvl;
    end

    assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/serial_key_lock.sv
// Multi-level serial key checker: words shifted in MSB-first on a slow
// strobe are compared against per-level keys; NUM_KEYS matches unlock,
// MAX_FAILS consecutive mismatches force a timed lockout.
// Define SHIFT_DEBOUNCE_EN to debounce the shift strobe.
module serial_key_lock
    import serial_key_lock_pkg::*;
#(
    parameter int                          KEY_W           = 16,
    parameter int                          NUM_KEYS        = 4,
    parameter logic [NUM_KEYS*KEY_W-1:0]   KEYS            = 64'hBEEF_CAFE_1337_39C3,
    parameter int                          MAX_FAILS       = 3,
    parameter int                          LOCKOUT_CYCLES  = 1024,
    parameter int                          SYNC_STAGES     = 2,
    parameter int                          DEBOUNCE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            shift,
    input  logic                            d,
    output logic                            led_ok,
    output logic                            led_fail,
    output logic [$clog2(NUM_KEYS+1)-1:0]   level,
    output logic [$clog2(KEY_W+1)-1:0]      bit_cnt
);

    localparam int LV_W = $clog2(NUM_KEYS + 1);
    localparam int BC_W = $clog2(KEY_W + 1);
    localparam int FC_W = cnt_width(MAX_FAILS);
    localparam int LT_W = cnt_width(LOCKOUT_CYCLES - 1);

`ifdef SHIFT_DEBOUNCE_EN
    localparam bit SHIFT_DEBOUNCE = 1'b1;
`else
    localparam bit SHIFT_DEBOUNCE = 1'b0;
`endif

    state_t                 state;
    state_t                 state_nxt;
    logic [KEY_W-1:0]       shreg;
    logic [FC_W-1:0]        fail_cnt;
    logic [LT_W-1:0]        lock_tmr;
    logic [SYNC_STAGES-1:0] d_sync_r;
    logic                   d_sync;
    logic                   shift_rise;
    logic [KEY_W-1:0]       cur_key;
    logic                   key_match;

    sync_edge_det #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_EN     (SHIFT_DEBOUNCE),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_shift_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (shift),
        .rise     (shift_rise)
    );

    // Data only needs synchronising; it is sampled when the strobe edge fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_sync_r <= '0;
        else        d_sync_r <= {d_sync_r[SYNC_STAGES-2:0], d};
    end

    assign d_sync = d_sync_r[SYNC_STAGES-1];

    // Select the key for the current level; levels past the last key never reach CHECK.
    always_comb begin
        cur_key = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (level == LV_W'(k)) cur_key = KEYS[k*KEY_W +: KEY_W];
        end
    end

    assign key_match = (shreg == cur_key);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // FSM next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (shift_rise && bit_cnt == BC_W'(KEY_W - 1)) state_nxt = CHECK;
            end
            CHECK: begin
                if (key_match)
                    state_nxt = (level == LV_W'(NUM_KEYS - 1)) ? UNLOCKED : COLLECT;
                else
                    state_nxt = (fail_cnt >= FC_W'(MAX_FAILS - 1)) ? LOCKOUT : COLLECT;
            end
            UNLOCKED: state_nxt = UNLOCKED;
            LOCKOUT: begin
                if (lock_tmr == '0) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // FSM outputs: mismatch pulse lasts exactly the CHECK cycle, lockout holds led_fail.
    always_comb begin
        led_ok   = (state == UNLOCKED);
        led_fail = ((state == CHECK) && !key_match) || (state == LOCKOUT);
    end

    // Shift register, word/level/fail counters and lockout timer; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            level    <= '0;
            fail_cnt <= '0;
            lock_tmr <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (shift_rise) begin
                        shreg <= {shreg[KEY_W-2:0], d_sync};
                        if (bit_cnt != BC_W'(KEY_W)) bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                    if (key_match) begin
                        fail_cnt <= '0;
                        if (level != LV_W'(NUM_KEYS)) level <= level + 1'b1;
                    end else begin
                        level <= '0;
                        if (fail_cnt != FC_W'(MAX_FAILS)) fail_cnt <= fail_cnt + 1'b1;
                        if (fail_cnt >= FC_W'(MAX_FAILS - 1))
                            lock_tmr <= LT_W'(LOCKOUT_CYCLES - 1);
                    end
                end
                LOCKOUT: begin
                    if (lock_tmr == '0) begin
                        fail_cnt <= '0;
                        level    <= '0;
                    end else begin
                        lock_tmr <= lock_tmr - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_key_lock.sv
// Self-checking bench for serial_key_lock. A cycle-level reference model of
// the lock's rules predicts every output on every clock; directed scenarios
// add literal checks. Define SHIFT_DEBOUNCE_EN to exercise the debounced build.
module tb_serial_key_lock;

    localparam int          KEY_W           = 16;
    localparam int          NUM_KEYS        = 4;
    localparam logic [63:0] KEYS            = 64'hBEEF_CAFE_1337_39C3;
    localparam int          MAX_FAILS       = 3;
    localparam int          LOCKOUT_CYCLES  = 1024;
    localparam int          SYNC_STAGES     = 2;
    localparam int          DEBOUNCE_CYCLES = 16;

`ifdef SHIFT_DEBOUNCE_EN
    localparam int HOLD = 20;
    localparam int FILT = DEBOUNCE_CYCLES;
`else
    localparam int HOLD = 4;
    localparam int FILT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       shift = 1'b0;
    logic       d     = 1'b0;
    logic       led_ok;
    logic       led_fail;
    logic [2:0] level;
    logic [4:0] bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_key_lock dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift    (shift),
        .d        (d),
        .led_ok   (led_ok),
        .led_fail (led_fail),
        .level    (level),
        .bit_cnt  (bit_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit sh_q[$];        // sh_q[k] = shift sampled k clocks ago
    bit d_q[$];
    bit m_bits[$];      // bits of the pending word, oldest first
    int m_level;
    int m_fails;
    int m_lock_left;    // lockout clocks still to go
    bit m_pending;      // full word waiting for its check clock
    bit m_filt;
    bit m_rose_prev;
    int m_run;

    function automatic logic [15:0] key_of(input int k);
        logic [63:0] kv;
        kv = KEYS;
        return kv[k*16 +: 16];
    endfunction

    function automatic logic [15:0] bits_word();
        logic [15:0] w;
        w = '0;
        foreach (m_bits[i]) w = {w[14:0], m_bits[i]};
        return w;
    endfunction

    function automatic void model_reset();
        sh_q.delete();
        d_q.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) begin
            sh_q.push_back(1'b0);
            d_q.push_back(1'b0);
        end
        m_bits.delete();
        m_level     = 0;
        m_fails     = 0;
        m_lock_left = 0;
        m_pending   = 1'b0;
        m_filt      = 1'b0;
        m_rose_prev = 1'b0;
        m_run       = 0;
    endfunction

    function automatic void model_step(input bit sh, input bit dv);
        bit ev;
        bit sync_now;
        sh_q.push_front(sh);
        d_q.push_front(dv);
        void'(sh_q.pop_back());
        void'(d_q.pop_back());
        sync_now = sh_q[SYNC_STAGES];
        if (FILT == 0) begin
            ev = sync_now && !sh_q[SYNC_STAGES+1];
        end else begin
            // A filtered rise becomes visible one clock after the level flips.
            ev = m_rose_prev;
            m_rose_prev = 1'b0;
            if (sync_now != m_filt) begin
                m_run++;
                if (m_run == FILT) begin
                    m_filt      = sync_now;
                    m_run       = 0;
                    m_rose_prev = sync_now;
                end
            end else begin
                m_run = 0;
            end
        end
        if (m_pending) begin
            if (bits_word() == key_of(m_level)) begin
                m_level++;
                m_fails = 0;
            end else begin
                m_level = 0;
                m_fails++;
                if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
            end
            m_bits.delete();
            m_pending = 1'b0;
        end else if (m_level == NUM_KEYS) begin
            // unlocked: strobes ignored
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_level = 0;
            end
        end else if (ev) begin
            m_bits.push_back(d_q[SYNC_STAGES]);
            if (m_bits.size() == KEY_W) m_pending = 1'b1;
        end
    endfunction

    // ---------------- per-cycle compare + led_fail run monitor ----------------
    int fail_run    = 0;
    int last_run    = 0;
    int fail_pulses = 0;

    always @(posedge clk) begin
        bit exp_fail;
        if (!rst_n) model_reset();
        else        model_step(shift, d);
        #1;
        exp_fail = (m_lock_left > 0);
        if (m_pending && bits_word() != key_of(m_level)) exp_fail = 1'b1;
        check("cyc_led_ok",   32'(led_ok),   32'(m_level == NUM_KEYS));
        check("cyc_led_fail", 32'(led_fail), 32'(exp_fail));
        check("cyc_level",    32'(level),    32'(m_level));
        check("cyc_bit_cnt",  32'(bit_cnt),  32'(m_bits.size()));
        if (led_fail) begin
            fail_run++;
        end else begin
            if (fail_run > 0) begin
                last_run = fail_run;
                fail_pulses++;
            end
            fail_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        d     = b;
        shift = 1'b1;
        tick(HOLD);
        shift = 1'b0;
        tick(HOLD);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        tick(2);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic async_reset_pulse(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_led_ok"},   32'(led_ok),   32'd0);
        check({tag, "_led_fail"}, 32'(led_fail), 32'd0);
        check({tag, "_level"},    32'(level),    32'd0);
        check({tag, "_bit_cnt"},  32'(bit_cnt),  32'd0);
        @(negedge clk);
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;
        model_reset();
        tick(3);
        check("rst_led_ok",   32'(led_ok),   32'd0);
        check("rst_led_fail", 32'(led_fail), 32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_bit_cnt",  32'(bit_cnt),  32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1) first key matches
        fail_pulses = 0;
        send_word(16'h39C3);
        check("t1_level",    32'(level),        32'd1);
        check("t1_bit_cnt",  32'(bit_cnt),      32'd0);
        check("t1_no_fail",  32'(fail_pulses),  32'd0);
        check("t1_fail_cnt", 32'(dut.fail_cnt), 32'd0);

        // 2) remaining keys unlock, then strobes are ignored
        send_word(16'h1337);
        send_word(16'hCAFE);
        send_word(16'hBEEF);
        check("t2_level",  32'(level),  32'd4);
        check("t2_led_ok", 32'(led_ok), 32'd1);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        check("t2_hold_bit_cnt",  32'(bit_cnt),  32'd0);
        check("t2_hold_level",    32'(level),    32'd4);
        check("t2_hold_led_ok",   32'(led_ok),   32'd1);
        check("t2_hold_led_fail", 32'(led_fail), 32'd0);

        // 3) three mismatches -> lockout
        apply_reset();
        fail_pulses = 0;
        send_word(16'h0000);
        send_word(16'h0000);
        check("t3_two_pulses", 32'(fail_pulses),  32'd2);
        check("t3_fail_cnt2",  32'(dut.fail_cnt), 32'd2);
        send_word(16'h0000);
        check("t3_locked", 32'(led_fail), 32'd1);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        check("t3_lock_bit_cnt", 32'(bit_cnt), 32'd0);
        for (int i = 0; i < 3000 && led_fail; i++) tick(1);
        check("t3_lock_ended", 32'(led_fail), 32'd0);
        // mismatch pulse in CHECK followed directly by the full lockout
        check("t3_fail_run",    32'(last_run),     32'(LOCKOUT_CYCLES + 1));
        check("t3_pulses",      32'(fail_pulses),  32'd3);
        check("t3_after_level", 32'(level),        32'd0);
        check("t3_after_fails", 32'(dut.fail_cnt), 32'd0);

        // 4) a mismatch clears progress; a later match clears the fail count
        send_word(16'h39C3);
        send_word(16'h0000);
        check("t4_level0", 32'(level),        32'd0);
        check("t4_fails1", 32'(dut.fail_cnt), 32'd1);
        send_word(16'h39C3);
        check("t4_level1", 32'(level),        32'd1);
        check("t4_fails0", 32'(dut.fail_cnt), 32'd0);

        // 5) asynchronous reset mid-word and mid-lockout
        apply_reset();
        for (int i = 15; i >= 7; i--) send_bit(16'h39C3 >> i);
        check("t5_partial", 32'(bit_cnt), 32'd9);
        async_reset_pulse("t5_mid_word");
        send_word(16'h39C3);
        check("t5_word_level", 32'(level), 32'd1);
        send_word(16'h0000);
        send_word(16'h0000);
        send_word(16'h0000);
        tick(100);
        check("t5_in_lockout", 32'(led_fail), 32'd1);
        async_reset_pulse("t5_mid_lock");
        send_word(16'h39C3);
        check("t5_lock_level", 32'(level),        32'd1);
        check("t5_lock_fails", 32'(dut.fail_cnt), 32'd0);

        // strobe-to-capture latency
        apply_reset();
        d     = 1'b1;
        shift = 1'b1;
        lat   = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bit_cnt == 5'd1) break;
        end
        @(negedge clk);
        tick(HOLD);
        shift = 1'b0;
        tick(HOLD);
        check("latency", 32'(lat), 32'(SYNC_STAGES + 1 + FILT));

`ifdef SHIFT_DEBOUNCE_EN
        // 6) short glitch is filtered out
        apply_reset();
        shift = 1'b1;
        tick(5);
        shift = 1'b0;
        tick(40);
        check("t6_glitch", 32'(bit_cnt), 32'd0);
`endif

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
